// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-bus bundle between the load/store stage and memory.
//   master side (the LSU) drives mem_req, mem_we, mem_addr, mem_wdata, mem_be
//   and receives mem_gnt, mem_rvalid, mem_rdata; the slave side is the mirror.
//   mem_req     request; mem_we write; mem_addr word-aligned byte address
//   mem_wdata   lane-replicated store data; mem_be byte enables
//   mem_gnt     request accepted; mem_rvalid read data valid; mem_rdata read data
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: load/store stage directly downstream of execute.
//   Runs L/S-type instructions over a req/gnt/rvalid bus, stalls the pipe via
//   hold_flag_o while an access is in flight, and registers the GPR write-back
//   for every instruction (non-memory results pass through with one cycle of
//   latency).
// Parameters
//   BUS_TIMEOUT  cycles allowed in REQ+WAIT before the access is aborted
//                with a bus_err_o pulse; 0 disables the timeout.
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned LH/LHU/SH/LW/SW make no bus
//                         access and pulse bus_err_o instead; when undefined the
//                         low address bits below the access size are ignored.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   valid_i, inst_i, inst_addr_i   instruction presented by execute
//   reg_we_i/reg_waddr_i/reg_wdata_i  execute write-back (rd also used by loads)
//   mem_addr_i, mem_wdata_i     effective address and store data
//   hold_flag_o                 stall upstream, high while not IDLE
//   bus                         data bus (lsu_mem_if.master)
//   reg_we_o/reg_waddr_o/reg_wdata_o  registered GPR write-back
//   inst_o, inst_addr_o         registered retired instruction / address
//   bus_err_o                   one-cycle pulse on timeout (or misalign trap)
module lsu_mem #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        hold_flag_o,
    lsu_mem_if.master   bus,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        bus_err_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Load data extraction: byte lane from off, half lane from off[1].
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    // Byte enables from access size (funct3[1:0]) and low address bits.
    function automatic logic [3:0] size_be(input logic [1:0] sz,
                                           input logic [1:0] off);
        case (sz)
            2'b00:   size_be = 4'b0001 << off;
            2'b01:   size_be = off[1] ? 4'b1100 : 4'b0011;
            default: size_be = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the slave picks it up via be.
    function automatic logic [31:0] store_data(input logic [1:0]  sz,
                                               input logic [31:0] d);
        case (sz)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;

    logic        op_load, op_store, is_load, is_store, misalign, timeout;
    logic [2:0]  f3;
    logic [1:0]  off;

    assign f3       = inst_i[14:12];
    assign off      = mem_addr_i[1:0];
    assign op_load  = (inst_i[6:0] == OP_LOAD);
    assign op_store = (inst_i[6:0] == OP_STORE);
    // Valid loads: LB/LH/LW/LBU/LHU; valid stores: SB/SH/SW.
    assign is_load  = op_load && (f3 != 3'b011) && (f3[2:1] != 2'b11);
    assign is_store = op_store && !f3[2] && (f3[1:0] != 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (f3[1:0] == 2'b01) ? off[0] :
                      (f3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
`else
    assign misalign = 1'b0;
`endif

    // cnt_q counts cycles already spent in REQ/WAIT before the current one,
    // so the abort fires in the BUS_TIMEOUT-th busy cycle.
    assign timeout = (BUS_TIMEOUT != 0) && (cnt_q >= BUS_TIMEOUT - 1);

    always_comb begin
        logic load_done;
        load_done   = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        bus_err_d   = 1'b0;
        off_d       = off_q;
        rd_d        = rd_q;
        f3_d        = f3_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    inst_d      = inst_i;
                    inst_addr_d = inst_addr_i;
                    if ((is_load || is_store) && !misalign) begin
                        mem_addr_d  = {mem_addr_i[31:2], 2'b00};
                        mem_we_d    = is_store;
                        mem_be_d    = size_be(f3[1:0], off);
                        mem_wdata_d = store_data(f3[1:0], mem_wdata_i);
                        off_d       = off;
                        rd_d        = reg_waddr_i;
                        f3_d        = f3;
                        cnt_d       = 32'd0;
                        state_d     = S_REQ;
                    end else if (is_load || is_store) begin
                        bus_err_d = 1'b1;
                    end else begin
                        // Load/store opcodes with a reserved funct3 retire silently.
                        reg_we_d    = reg_we_i && !op_load && !op_store &&
                                      (reg_waddr_i != 5'd0);
                        reg_waddr_d = reg_waddr_i;
                        reg_wdata_d = reg_wdata_i;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                // A completion in the last allowed cycle wins over the abort;
                // a load granted then without data is aborted.
                if (bus.mem_gnt && mem_we_q) begin
                    state_d = S_IDLE;
                end else if (bus.mem_gnt && bus.mem_rvalid) begin
                    load_done = 1'b1;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else if (bus.mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (bus.mem_rvalid) begin
                    load_done = 1'b1;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_done) begin
            state_d     = S_IDLE;
            reg_we_d    = (rd_q != 5'd0);
            reg_waddr_d = rd_q;
            reg_wdata_d = load_extract(bus.mem_rdata, f3_q, off_q);
        end
    end

    // Registered stage: control and every output-visible register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= 5'd0;
            reg_wdata_q <= 32'd0;
            inst_q      <= 32'd0;
            inst_addr_q <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Access context only read while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        off_q <= off_d;
        rd_q  <= rd_d;
        f3_q  <= f3_d;
    end

    assign hold_flag_o   = (state_q != S_IDLE);
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign reg_we_o      = reg_we_q;
    assign reg_waddr_o   = reg_waddr_q;
    assign reg_wdata_o   = reg_wdata_q;
    assign inst_o        = inst_q;
    assign inst_addr_o   = inst_addr_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: bench for lsu_mem (BUS_TIMEOUT = 4). Directed vector table,
// hand-written reset/misalign sequences, then randomized operations checked
// against a behavioural model of the load/store rules.
module tb_lsu_mem;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] inst_i, inst_addr_i, reg_wdata_i, mem_addr_i, mem_wdata_i;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic        hold_flag_o, reg_we_o, bus_err_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o, inst_o, inst_addr_o;

    lsu_mem_if bus();

    lsu_mem #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .reg_wdata_i(reg_wdata_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .hold_flag_o(hold_flag_o), .bus(bus), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req, hold, we, wbc, err, errc, unst;
        logic [31:0] wdata, baddr, bwd, inst;
        logic [4:0]  waddr;
        logic [3:0]  be;
        logic        bwe;
    } res_t;

    typedef struct {
        logic [31:0] inst, maddr, mwdata, rwdata, rdata;
        logic [4:0]  rd;
        logic        rwe;
        int          gd, rdl;
        res_t        exp;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        mk = {17'd0, f3, rd, op};
    endfunction

    function automatic res_t mkres(int req, int hold, int we, int wbc, logic [31:0] wdata,
                                   logic [4:0] waddr, int err, int errc, logic [31:0] baddr,
                                   logic bwe, logic [3:0] be, logic [31:0] bwd);
        res_t r;
        r = '{default: 0};
        r.req = req; r.hold = hold; r.we = we; r.wbc = wbc; r.wdata = wdata;
        r.waddr = waddr; r.err = err; r.errc = errc; r.baddr = baddr;
        r.bwe = bwe; r.be = be; r.bwd = bwd;
        return r;
    endfunction

    task automatic addv(input logic [31:0] inst, maddr, mwdata, input logic [4:0] rd,
                        input logic rwe, input logic [31:0] rwdata, input int gd, rdl,
                        input logic [31:0] rdata, input res_t e);
        vec_t v;
        v.inst = inst; v.maddr = maddr; v.mwdata = mwdata; v.rd = rd; v.rwe = rwe;
        v.rwdata = rwdata; v.gd = gd; v.rdl = rdl; v.rdata = rdata; v.exp = e;
        v.exp.inst = inst;
        vecs.push_back(v);
    endtask

    // Behavioural reference: what a load/store stage should do with one instruction
    // given a bus that grants after gd request cycles and returns data rdl cycles later.
    function automatic res_t model(input vec_t v);
        res_t e;
        int op, f3, off, bytes, lane, total;
        bit load, store;
        logic [31:0] mask, val;
        e = '{default: 0};
        e.inst = v.inst;
        op = int'(v.inst[6:0]);
        f3 = int'(v.inst[14:12]);
        off = int'(v.maddr % 4);
        load  = (op == 3) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        store = (op == 35) && (f3 <= 2);
        if (!load && !store) begin
            if (v.rwe && v.rd != 0 && op != 3 && op != 35) begin
                e.we = 1; e.wbc = 1; e.wdata = v.rwdata; e.waddr = v.rd;
            end
            return e;
        end
        bytes = 1 << (f3 % 4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % bytes != 0) begin
            e.err = 1; e.errc = 1;
            return e;
        end
`endif
        lane = (off / bytes) * bytes;
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 1);
        e.baddr = v.maddr & ~32'd3;
        e.bwe = store;
        if (store) begin
            e.be = 4'(((1 << bytes) - 1) << lane);
            e.bwd = (bytes == 1) ? (v.mwdata & 32'hFF) * 32'h0101_0101 :
                    (bytes == 2) ? (v.mwdata & 32'hFFFF) * 32'h0001_0001 : v.mwdata;
        end
        total = store ? v.gd + 1 : v.gd + 1 + v.rdl;
        if (total <= TMO) begin
            e.req = v.gd + 1;
            e.hold = total;
            if (load && v.rd != 0) begin
                val = (v.rdata >> (8 * lane)) & mask;
                if (f3 < 4 && bytes < 4 && val[8 * bytes - 1]) val = val | ~mask;
                e.we = 1; e.wbc = total + 1; e.wdata = val; e.waddr = v.rd;
            end
        end else begin
            e.req = (v.gd + 1 < TMO) ? v.gd + 1 : TMO;
            e.hold = TMO;
            e.err = 1;
            e.errc = TMO + 1;
        end
        return e;
    endfunction

    // Issue one instruction, act as the bus slave for 8 cycles, record what happened.
    task automatic run_op(input vec_t v, input logic [31:0] iaddr, output res_t o);
        int rq, wt;
        bit granted;
        o = '{default: 0};
        rq = 0; wt = 0; granted = 0;
        @(negedge clk);
        valid_i = 1'b1; inst_i = v.inst; inst_addr_i = iaddr;
        reg_we_i = v.rwe; reg_waddr_i = v.rd; reg_wdata_i = v.rwdata;
        mem_addr_i = v.maddr; mem_wdata_i = v.mwdata;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = v.rdata;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (c == 1) o.inst = inst_o;
            if (reg_we_o) begin
                if (o.we == 0) begin o.wbc = c; o.wdata = reg_wdata_o; o.waddr = reg_waddr_o; end
                o.we++;
            end
            if (bus_err_o) begin
                if (o.err == 0) o.errc = c;
                o.err++;
            end
            if (hold_flag_o) o.hold++;
            if (bus.mem_req) begin
                if (o.req == 0) begin
                    o.baddr = bus.mem_addr; o.bwe = bus.mem_we; o.be = bus.mem_be; o.bwd = bus.mem_wdata;
                end else if (o.baddr !== bus.mem_addr || o.bwe !== bus.mem_we ||
                             o.be !== bus.mem_be || o.bwd !== bus.mem_wdata) begin
                    o.unst++;
                end
                o.req++;
                bus.mem_gnt = (rq == v.gd);
                bus.mem_rvalid = (rq == v.gd) && (v.rdl == 0);
                if (rq == v.gd) granted = 1;
                rq++;
            end else if (granted && hold_flag_o) begin
                wt++;
                bus.mem_gnt = 1'b0;
                bus.mem_rvalid = (wt == v.rdl);
            end else begin
                bus.mem_gnt = 1'b0;
                bus.mem_rvalid = 1'b0;
            end
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t o, input res_t e);
        chk({tag, "/req"}, 32'(o.req), 32'(e.req));
        chk({tag, "/hold"}, 32'(o.hold), 32'(e.hold));
        chk({tag, "/we"}, 32'(o.we), 32'(e.we));
        chk({tag, "/err"}, 32'(o.err), 32'(e.err));
        chk({tag, "/inst"}, o.inst, e.inst);
        if (e.err > 0) chk({tag, "/errc"}, 32'(o.errc), 32'(e.errc));
        if (e.we > 0) begin
            chk({tag, "/wbc"}, 32'(o.wbc), 32'(e.wbc));
            chk({tag, "/wdata"}, o.wdata, e.wdata);
            chk({tag, "/waddr"}, 32'(o.waddr), 32'(e.waddr));
        end
        if (e.req > 0) begin
            chk({tag, "/baddr"}, o.baddr, e.baddr);
            chk({tag, "/bwe"}, 32'(o.bwe), 32'(e.bwe));
            chk({tag, "/stable"}, 32'(o.unst), 32'd0);
        end
        if (e.bwe) begin
            chk({tag, "/be"}, 32'(o.be), 32'(e.be));
            chk({tag, "/bwd"}, o.bwd, e.bwd);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "/hold"}, 32'(hold_flag_o), 32'd0);
        chk({tag, "/req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "/reg_we"}, 32'(reg_we_o), 32'd0);
        chk({tag, "/bus_err"}, 32'(bus_err_o), 32'd0);
    endtask

    initial begin
        res_t o, e;
        vec_t v;
        res_t z;
        z = '{default: 0};

        // Directed vectors: inst, addr, store data, rd, reg_we, exec result, gnt delay,
        // rvalid delay, rdata | expected req, hold, we, wb cycle, wdata, waddr, err,
        // err cycle, bus addr, bus we, be, bus wdata.
        addv(mk(7'h33, 3'd0, 5'd5), 0, 0, 5'd5, 1, 32'h1234, 0, 0, 0,
             mkres(0, 0, 1, 1, 32'h1234, 5'd5, 0, 0, 0, 0, 0, 0));
        addv(mk(7'h03, 3'd0, 5'd6), 32'h1003, 0, 5'd6, 0, 0, 1, 1, 32'h80FF_FFFF,
             mkres(2, 3, 1, 4, 32'hFFFF_FF80, 5'd6, 0, 0, 32'h1000, 0, 0, 0));
        addv(mk(7'h03, 3'd4, 5'd6), 32'h1003, 0, 5'd6, 0, 0, 1, 1, 32'h80FF_FFFF,
             mkres(2, 3, 1, 4, 32'h0000_0080, 5'd6, 0, 0, 32'h1000, 0, 0, 0));
        addv(mk(7'h23, 3'd1, 5'd0), 32'h2002, 32'hABCD_1234, 5'd0, 0, 0, 0, 0, 0,
             mkres(1, 1, 0, 0, 0, 5'd0, 0, 0, 32'h2000, 1, 4'b1100, 32'h1234_1234));
        addv(mk(7'h03, 3'd2, 5'd7), 32'h3000, 0, 5'd7, 0, 0, 0, 0, 32'hDEAD_BEEF,
             mkres(1, 1, 1, 2, 32'hDEAD_BEEF, 5'd7, 0, 0, 32'h3000, 0, 0, 0));
        addv(mk(7'h03, 3'd2, 5'd8), 32'h3004, 0, 5'd8, 0, 0, 9, 0, 32'h5555_5555,
             mkres(4, 4, 0, 0, 0, 5'd0, 1, 5, 32'h3004, 0, 0, 0));
        addv(mk(7'h33, 3'd0, 5'd0), 0, 0, 5'd0, 1, 32'h55, 0, 0, 0, z);
        addv(mk(7'h03, 3'd1, 5'd9), 32'h4002, 0, 5'd9, 0, 0, 0, 1, 32'h8001_7FFF,
             mkres(1, 2, 1, 3, 32'hFFFF_8001, 5'd9, 0, 0, 32'h4000, 0, 0, 0));
        addv(mk(7'h03, 3'd5, 5'd10), 32'h4000, 0, 5'd10, 0, 0, 0, 0, 32'h1234_8765,
             mkres(1, 1, 1, 2, 32'h0000_8765, 5'd10, 0, 0, 32'h4000, 0, 0, 0));
        addv(mk(7'h23, 3'd0, 5'd0), 32'h5001, 32'h0000_00A5, 5'd0, 0, 0, 1, 0, 0,
             mkres(2, 2, 0, 0, 0, 5'd0, 0, 0, 32'h5000, 1, 4'b0010, 32'hA5A5_A5A5));
        addv(mk(7'h23, 3'd2, 5'd0), 32'h6000, 32'hCAFE_F00D, 5'd0, 0, 0, 2, 0, 0,
             mkres(3, 3, 0, 0, 0, 5'd0, 0, 0, 32'h6000, 1, 4'b1111, 32'hCAFE_F00D));
        addv(mk(7'h03, 3'd3, 5'd11), 32'h7000, 0, 5'd11, 1, 32'h99, 0, 0, 0, z);
        addv(mk(7'h03, 3'd2, 5'd0), 32'h7008, 0, 5'd0, 0, 0, 0, 0, 32'h1,
             mkres(1, 1, 0, 0, 0, 5'd0, 0, 0, 32'h7008, 0, 0, 0));
        addv(mk(7'h03, 3'd0, 5'd12), 32'h8001, 0, 5'd12, 0, 0, 0, 2, 32'h1234_7F56,
             mkres(1, 3, 1, 4, 32'h0000_007F, 5'd12, 0, 0, 32'h8000, 0, 0, 0));
        addv(mk(7'h23, 3'd2, 5'd0), 32'h9000, 32'h1111_1111, 5'd0, 0, 0, 9, 0, 0,
             mkres(4, 4, 0, 0, 0, 5'd0, 1, 5, 32'h9000, 1, 4'b1111, 32'h1111_1111));

        valid_i = 0; inst_i = 0; inst_addr_i = 0; reg_we_i = 0; reg_waddr_i = 0;
        reg_wdata_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset/addr", bus.mem_addr, 32'd0);
        chk("reset/wdata", bus.mem_wdata, 32'd0);
        chk("reset/be", 32'(bus.mem_be), 32'd0);
        chk("reset/inst", inst_o, 32'd0);
        chk("reset/reg_wdata", reg_wdata_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], 32'h100 + 32'(4 * i), o);
            cmp_res($sformatf("vec%0d", i), o, vecs[i].exp);
        end

        // LW to 0x1002: trap with the misalign feature, word access at 0x1000 without.
        v = vecs[4];
        v.maddr = 32'h1002; v.rd = 5'd4; v.inst = mk(7'h03, 3'd2, 5'd4); v.rdata = 32'h1122_3344;
`ifdef LSU_MISALIGN_TRAP_EN
        e = mkres(0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, 0, 0);
`else
        e = mkres(1, 1, 1, 2, 32'h1122_3344, 5'd4, 0, 0, 32'h1000, 0, 0, 0);
`endif
        e.inst = v.inst;
        run_op(v, 32'h200, o);
        cmp_res("misalign_lw", o, e);

        // Reset while in WAIT, then a late rvalid while idle must be ignored.
        @(negedge clk);
        valid_i = 1; inst_i = mk(7'h03, 3'd2, 5'd3); reg_waddr_i = 5'd3; mem_addr_i = 32'h300;
        @(negedge clk);
        valid_i = 0;
        chk("rstwait/req", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1;
        @(negedge clk);
        bus.mem_gnt = 0;
        chk("rstwait/hold", 32'(hold_flag_o), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_idle_outputs("rstwait");
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        bus.mem_rvalid = 0;
        chk_idle_outputs("late_rvalid");

        // Reset while in REQ drops the request on the next cycle.
        valid_i = 1; inst_i = mk(7'h23, 3'd2, 5'd0); mem_addr_i = 32'h400;
        @(negedge clk);
        valid_i = 0;
        chk("rstreq/req", 32'(bus.mem_req), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_idle_outputs("rstreq");

        // Randomized operations against the model.
        for (int i = 0; i < 120; i++) begin
            int kind;
            logic [6:0] op;
            kind = $urandom_range(0, 4);
            op = (kind == 0) ? 7'h33 : (kind == 1) ? 7'h13 : (kind == 4) ? 7'h23 : 7'h03;
            v.inst = $urandom;
            v.inst[6:0] = op;
            v.maddr = $urandom;
            v.mwdata = $urandom;
            v.rd = 5'($urandom_range(0, 31));
            v.rwe = 1'($urandom_range(0, 1));
            v.rwdata = $urandom;
            v.gd = $urandom_range(0, 5);
            v.rdl = $urandom_range(0, 3);
            v.rdata = $urandom;
            e = model(v);
            run_op(v, $urandom, o);
            cmp_res($sformatf("rnd%0d", i), o, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
